// File: rtl/operand_fetch_stage_pkg.sv
`default_nettype none
//==============================================================================
// Package : operand_fetch_stage_pkg
// Desc    : MIPS opcode/funct constants and instruction field decode for ID.
// Rev     : 1.0
//==============================================================================
package operand_fetch_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        regwrite;
        logic        memread;
        logic        rt_used;
        logic [31:0] imm;
    } decode_t;

    function automatic decode_t f_decode(input logic [31:0] instr);
        decode_t d;
        d.opcode = instr[31:26];
        d.funct  = instr[5:0];
        d.rs     = instr[25:21];
        d.rt     = instr[20:16];
        d.imm    = {{16{instr[15]}}, instr[15:0]};
        d.dest   = (d.opcode == OP_RTYPE) ? instr[15:11] : instr[20:16];
        case (d.opcode)
            OP_RTYPE: d.regwrite = (d.funct != FN_JR);
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW: d.regwrite = 1'b1;
            default:  d.regwrite = 1'b0;
        endcase
        // Writes to $0 are architecturally void; never advertise them downstream.
        if (d.dest == 5'd0) begin
            d.regwrite = 1'b0;
        end
        d.memread = (d.opcode == OP_LW);
        // An I-type rt is a destination, not a source, except for stores and branches.
        d.rt_used = (d.opcode == OP_RTYPE) || (d.opcode == OP_BEQ) || (d.opcode == OP_BNE) ||
                    (d.opcode == OP_SB)    || (d.opcode == OP_SH)  || (d.opcode == OP_SW);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
//==============================================================================
// Module : operand_bypass
// Desc   : Priority operand select: $0, EX/MEM result, MEM/WB data, register file.
// Rev    : 1.0
//==============================================================================
module operand_bypass #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      src,
    input  logic [XLEN-1:0] rf_data,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_dest,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_dest,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (src == 5'd0) begin
            operand = '0;
        end else if (mem_regwrite && (mem_dest == src)) begin
            operand = mem_result;
        end else if (wb_regwrite && (wb_dest == src)) begin
            operand = wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
//==============================================================================
// Module : operand_fetch_stage
// Desc   : MIPS ID stage: decode, operand select, hazard stall, ID/EX register.
//          FORWARDING_EN: bypass network + load-use detect; otherwise a pending
//          register scoreboard stalls until write-back.
// Rev    : 1.0
//==============================================================================
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [$clog2(NREG)-1:0] readReg1,
    output logic [$clog2(NREG)-1:0] readReg2,
    input  logic [XLEN-1:0]         readData1,
    input  logic [XLEN-1:0]         readData2,
    input  logic                    mem_regwrite,
    input  logic [4:0]              mem_dest,
    input  logic [XLEN-1:0]         mem_result,
    input  logic                    wb_regwrite,
    input  logic [4:0]              wb_dest,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    ex_ready,
    output logic                    ex_valid,
    output logic [XLEN-1:0]         ex_pc,
    output logic [XLEN-1:0]         ex_rs_val,
    output logic [XLEN-1:0]         ex_rt_val,
    output logic [XLEN-1:0]         ex_imm,
    output logic [5:0]              ex_opcode,
    output logic [5:0]              ex_funct,
    output logic [4:0]              ex_dest,
    output logic                    ex_regwrite,
    output logic                    ex_memread
);

    decode_t         w_dec;
    logic            w_stall;
    logic            w_accept;
    logic            w_mem_en;
    logic            w_wb_en;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_rs_val;
    logic [XLEN-1:0] r_ex_rt_val;
    logic [XLEN-1:0] r_ex_imm;
    logic [5:0]      r_ex_opcode;
    logic [5:0]      r_ex_funct;
    logic [4:0]      r_ex_dest;
    logic            r_ex_regwrite;
    logic            r_ex_memread;

    assign w_dec    = f_decode(in_instr);
    assign readReg1 = w_dec.rs;
    assign readReg2 = w_dec.rt;
    assign w_accept = ex_ready && !w_stall && !flush;
    assign in_ready = w_accept;

`ifdef FORWARDING_EN
    assign w_mem_en = mem_regwrite;
    assign w_wb_en  = wb_regwrite;
    assign w_stall  = r_ex_valid && r_ex_memread && (r_ex_dest != 5'd0) &&
                      ((r_ex_dest == w_dec.rs) || (w_dec.rt_used && (r_ex_dest == w_dec.rt)));
`else
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_set;
    logic [NREG-1:0] w_pending_clr;
    logic            w_unused_fwd;

    assign w_mem_en     = 1'b0;
    assign w_wb_en      = 1'b0;
    assign w_unused_fwd = mem_regwrite ^ w_dec.rt_used;
    // Bit stays set through the write-back cycle, so the register file is
    // already updated when the dependent instruction finally reads it.
    assign w_stall      = r_pending[w_dec.rs] | r_pending[w_dec.rt];

    always_comb begin
        w_pending_set = '0;
        w_pending_clr = '0;
        if (wb_regwrite) begin
            w_pending_clr[wb_dest] = 1'b1;
        end
        if (w_accept && in_valid && w_dec.regwrite) begin
            w_pending_set[w_dec.dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pending_clr) | w_pending_set;
        end
    end
`endif

    operand_bypass #(.XLEN(XLEN)) u_rs_bypass (
        .src          (w_dec.rs),
        .rf_data      (readData1),
        .mem_regwrite (w_mem_en),
        .mem_dest     (mem_dest),
        .mem_result   (mem_result),
        .wb_regwrite  (w_wb_en),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .operand      (w_rs_val)
    );

    operand_bypass #(.XLEN(XLEN)) u_rt_bypass (
        .src          (w_dec.rt),
        .rf_data      (readData2),
        .mem_regwrite (w_mem_en),
        .mem_dest     (mem_dest),
        .mem_result   (mem_result),
        .wb_regwrite  (w_wb_en),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .operand      (w_rt_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs_val   <= '0;
            r_ex_rt_val   <= '0;
            r_ex_imm      <= '0;
            r_ex_opcode   <= '0;
            r_ex_funct    <= '0;
            r_ex_dest     <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else if (flush) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else if (ex_ready) begin
            if (!w_stall) begin
                r_ex_valid    <= in_valid;
                r_ex_pc       <= in_pc;
                r_ex_rs_val   <= w_rs_val;
                r_ex_rt_val   <= w_rt_val;
                r_ex_imm      <= w_dec.imm;
                r_ex_opcode   <= w_dec.opcode;
                r_ex_funct    <= w_dec.funct;
                r_ex_dest     <= w_dec.dest;
                r_ex_regwrite <= in_valid && w_dec.regwrite;
                r_ex_memread  <= in_valid && w_dec.memread;
            end else begin
                r_ex_valid    <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs_val   = r_ex_rs_val;
    assign ex_rt_val   = r_ex_rt_val;
    assign ex_imm      = r_ex_imm;
    assign ex_opcode   = r_ex_opcode;
    assign ex_funct    = r_ex_funct;
    assign ex_dest     = r_ex_dest;
    assign ex_regwrite = r_ex_regwrite;
    assign ex_memread  = r_ex_memread;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
//==============================================================================
// Module : tb_operand_fetch_stage
// Desc   : Self-checking bench for operand_fetch_stage (honours FORWARDING_EN).
// Rev    : 1.0
//==============================================================================
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, ex_ready;
    logic [31:0] in_instr, in_pc, readData1, readData2;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_dest, wb_dest;
    logic [31:0] mem_result, wb_data;
    logic        in_ready;
    logic [4:0]  readReg1, readReg2;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_dest;

    int total = 0;
    int bad   = 0;

    // Reference model of the ID/EX contents and the pending-write set
    logic        m_valid, m_rw, m_mr;
    logic [31:0] m_pc, m_rs, m_rt, m_imm, m_pend;
    logic [5:0]  m_op, m_fn;
    logic [4:0]  m_dest;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .mem_regwrite(mem_regwrite), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
    );

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit writes_reg(logic [31:0] ins);
        if (ins[31:26] == 6'h00) return ins[5:0] != 6'h08;
        return ins[31:26] inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23};
    endfunction

    function automatic logic [4:0] dest_of(logic [31:0] ins);
        return (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    endfunction

    function automatic bit uses_rt(logic [31:0] ins);
        return ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic logic [31:0] model_operand(logic [4:0] src, logic [31:0] rf);
        if (src == 5'd0) return 32'd0;
`ifdef FORWARDING_EN
        if (mem_regwrite && mem_dest == src) return mem_result;
        if (wb_regwrite && wb_dest == src) return wb_data;
`endif
        return rf;
    endfunction

    function automatic bit model_stall();
        logic [4:0] rs, rt;
        rs = in_instr[25:21];
        rt = in_instr[20:16];
`ifdef FORWARDING_EN
        return m_valid && m_mr && (m_dest != 5'd0) &&
               ((m_dest == rs) || (uses_rt(in_instr) && m_dest == rt));
`else
        return m_pend[rs] || m_pend[rt];
`endif
    endfunction

    function automatic bit model_ready();
        return ex_ready && !model_stall() && !flush;
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        bit st, rw;
        logic [4:0]  d;
        logic [31:0] nrs, nrt, npend;
        st    = model_stall();
        d     = dest_of(in_instr);
        rw    = writes_reg(in_instr) && (d != 5'd0);
        nrs   = model_operand(in_instr[25:21], readData1);
        nrt   = model_operand(in_instr[20:16], readData2);
        npend = m_pend;
        if (wb_regwrite) npend[wb_dest] = 1'b0;
        if (!flush && ex_ready && !st && in_valid && rw) npend[d] = 1'b1;
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_pc = 0; m_rs = 0; m_rt = 0;
            m_imm = 0; m_op = 0; m_fn = 0; m_dest = 0; m_pend = 0;
        end else begin
            m_pend = npend;
            if (flush) begin
                m_valid = 0; m_rw = 0; m_mr = 0;
            end else if (ex_ready) begin
                if (!st) begin
                    m_valid = in_valid;
                    m_pc    = in_pc;
                    m_rs    = nrs;
                    m_rt    = nrt;
                    m_imm   = {{16{in_instr[15]}}, in_instr[15:0]};
                    m_op    = in_instr[31:26];
                    m_fn    = in_instr[5:0];
                    m_dest  = d;
                    m_rw    = in_valid && rw;
                    m_mr    = in_valid && (in_instr[31:26] == 6'h23);
                end else begin
                    m_valid = 0; m_rw = 0; m_mr = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; in_valid = 0; flush = 0; ex_ready = 1;
        in_instr = 32'd0; in_pc = 32'd0;
        readData1 = 32'd0; readData2 = 32'd0;
        mem_regwrite = 0; mem_dest = 0; mem_result = 0;
        wb_regwrite = 0; wb_dest = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; in_valid = 1; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        tick(); tick();
        total++;
        if ({ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_opcode, ex_funct,
             ex_dest, ex_regwrite, ex_memread} !== '0) begin
            bad++; $display("FAIL reset_ex_zero got pc=%h valid=%b rw=%b", ex_pc, ex_valid, ex_regwrite);
        end
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_hi got=%b exp=1", in_ready); end
        ex_ready = 0; #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_lo got=%b exp=0", in_ready); end
        idle();
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        in_valid = 1; in_pc = 32'h100; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        readData1 = 32'h11; readData2 = 32'h22;
        tick();
        total++;
        if ({ex_valid, ex_dest, ex_regwrite, ex_rs_val, ex_imm} !== {1'b1, 5'd3, 1'b1, 32'h11, 32'h1820}) begin
            bad++; $display("FAIL fwd_add got v=%b d=%0d rw=%b rs=%h imm=%h exp 1/3/1/11/1820",
                            ex_valid, ex_dest, ex_regwrite, ex_rs_val, ex_imm);
        end
        in_pc = 32'h104; in_instr = rtype(5'd3, 5'd1, 5'd4, 6'h22);
        readData1 = 32'hBAD0; readData2 = 32'h11;
        mem_regwrite = 1; mem_dest = 3; mem_result = 32'h55;
        #1;
`ifdef FORWARDING_EN
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%b exp=1", in_ready); end
        tick();
`else
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL sb_stall got=%b exp=0", in_ready); end
        tick();
        mem_regwrite = 0; wb_regwrite = 1; wb_dest = 3; wb_data = 32'h55;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL sb_wb_hold got=%b exp=0", in_ready); end
        tick();
        wb_regwrite = 0; readData1 = 32'h55;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL sb_release got=%b exp=1", in_ready); end
        tick();
`endif
        total++;
        if ({ex_valid, ex_pc, ex_rs_val, ex_rt_val} !== {1'b1, 32'h104, 32'h55, 32'h11}) begin
            bad++; $display("FAIL fwd_sub got v=%b pc=%h rs=%h rt=%h exp 1/104/55/11",
                            ex_valid, ex_pc, ex_rs_val, ex_rt_val);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1; in_instr = itype(6'h23, 5'd1, 5'd5, 16'hFFFC);
        tick();
        total++;
        if ({ex_memread, ex_regwrite, ex_dest, ex_imm} !== {1'b1, 1'b1, 5'd5, 32'hFFFFFFFC}) begin
            bad++; $display("FAIL lw_decode got mr=%b rw=%b d=%0d imm=%h", ex_memread, ex_regwrite, ex_dest, ex_imm);
        end
        in_instr = rtype(5'd5, 5'd5, 5'd6, 6'h20);
        readData1 = 32'h0BAD; readData2 = 32'h0BAD;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b exp=0", in_ready); end
        tick();
        total++;
        if ({ex_valid, ex_memread, ex_regwrite} !== 3'b000) begin
            bad++; $display("FAIL lu_bubble got v=%b mr=%b rw=%b exp 000", ex_valid, ex_memread, ex_regwrite);
        end
        wb_regwrite = 1; wb_dest = 5; wb_data = 32'hCAFE;
`ifndef FORWARDING_EN
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_wb_hold got=%b exp=0", in_ready); end
        tick();
        wb_regwrite = 0; readData1 = 32'hCAFE; readData2 = 32'hCAFE;
`endif
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_issue got=%b exp=1", in_ready); end
        tick();
        total++;
        if ({ex_valid, ex_rs_val, ex_rt_val, ex_dest} !== {1'b1, 32'hCAFE, 32'hCAFE, 5'd6}) begin
            bad++; $display("FAIL lu_operands got v=%b rs=%h rt=%h d=%0d", ex_valid, ex_rs_val, ex_rt_val, ex_dest);
        end
    endtask

    task automatic test_wb_bypass();
        logic [31:0] exp_rs, exp_rt;
        do_reset();
        wb_regwrite = 1; wb_dest = 7; wb_data = 32'hDEADBEEF;
        in_valid = 1; in_instr = rtype(5'd7, 5'd0, 5'd8, 6'h20);
        readData1 = 32'h12345678; readData2 = 32'h9;
`ifdef FORWARDING_EN
        exp_rs = 32'hDEADBEEF;
`else
        exp_rs = 32'h12345678;
`endif
        tick();
        total++;
        if ({ex_rs_val, ex_rt_val} !== {exp_rs, 32'd0}) begin
            bad++; $display("FAIL wb_bypass got rs=%h rt=%h exp rs=%h rt=0", ex_rs_val, ex_rt_val, exp_rs);
        end
        mem_regwrite = 1; mem_dest = 7; mem_result = 32'hAAAA5555;
        in_instr = rtype(5'd0, 5'd7, 5'd9, 6'h20);
        readData1 = 32'h44; readData2 = 32'h66;
`ifdef FORWARDING_EN
        exp_rt = 32'hAAAA5555;
`else
        exp_rt = 32'h66;
`endif
        tick();
        total++;
        if ({ex_rs_val, ex_rt_val} !== {32'd0, exp_rt}) begin
            bad++; $display("FAIL mem_priority got rs=%h rt=%h exp rs=0 rt=%h", ex_rs_val, ex_rt_val, exp_rt);
        end
    endtask

    task automatic test_zero_dest();
        do_reset();
        in_valid = 1; in_instr = itype(6'h08, 5'd0, 5'd0, 16'd5); readData1 = 32'h77;
        tick();
        total++;
        if ({ex_valid, ex_regwrite, ex_dest, ex_rs_val, ex_imm} !== {1'b1, 1'b0, 5'd0, 32'd0, 32'd5}) begin
            bad++; $display("FAIL zero_addi got v=%b rw=%b d=%0d rs=%h imm=%h", ex_valid, ex_regwrite, ex_dest, ex_rs_val, ex_imm);
        end
        in_instr = itype(6'h23, 5'd0, 5'd0, 16'd0);
        tick();
        in_instr = rtype(5'd0, 5'd0, 5'd1, 6'h20);
        mem_regwrite = 1; mem_dest = 0; mem_result = 32'h99; readData2 = 32'h77;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_nostall got=%b exp=1", in_ready); end
        tick();
        total++;
        if ({ex_valid, ex_rs_val, ex_rt_val} !== {1'b1, 32'd0, 32'd0}) begin
            bad++; $display("FAIL zero_operand got v=%b rs=%h rt=%h exp 1/0/0", ex_valid, ex_rs_val, ex_rt_val);
        end
    endtask

    task automatic test_flush();
        bit exp_rdy;
        do_reset();
        in_valid = 1; in_instr = itype(6'h23, 5'd1, 5'd5, 16'd8);
        tick();
        in_instr = rtype(5'd5, 5'd5, 5'd6, 6'h20);
        ex_ready = 0; flush = 1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        tick();
        total++;
        if ({ex_valid, ex_memread, ex_regwrite} !== 3'b000) begin
            bad++; $display("FAIL flush_empty got v=%b mr=%b rw=%b exp 000", ex_valid, ex_memread, ex_regwrite);
        end
        flush = 0; ex_ready = 1;
`ifdef FORWARDING_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        #1;
        total++;
        if (in_ready !== exp_rdy) begin bad++; $display("FAIL flush_after got=%b exp=%b", in_ready, exp_rdy); end
        reset = 1; ex_ready = 0; flush = 1;
        tick();
        reset = 0; ex_ready = 1; flush = 0;
        #1;
        total++;
        if ({ex_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL reset_mid_stall got v=%b rdy=%b exp v=0 rdy=1", ex_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h23, 6'h08, 6'h09, 6'h0F, 6'h2B, 6'h04, 6'h0D, 6'h0A};
        logic [5:0] fns [3]  = '{6'h20, 6'h22, 6'h08};
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 9)];
            rs = 5'($urandom_range(0, 5));
            rt = 5'($urandom_range(0, 5));
            rd = 5'($urandom_range(0, 5));
            in_instr     = (op == 6'h00) ? rtype(rs, rt, rd, fns[$urandom_range(0, 2)])
                                         : itype(op, rs, rt, 16'($urandom));
            in_valid     = ($urandom_range(0, 9) != 0);
            in_pc        = $urandom;
            flush        = ($urandom_range(0, 15) == 0);
            ex_ready     = ($urandom_range(0, 4) != 0);
            reset        = ($urandom_range(0, 80) == 0);
            readData1    = $urandom;
            readData2    = $urandom;
            mem_regwrite = ($urandom_range(0, 2) == 0);
            mem_dest     = 5'($urandom_range(0, 5));
            mem_result   = $urandom;
            wb_regwrite  = ($urandom_range(0, 1) == 0);
            wb_dest      = 5'($urandom_range(0, 5));
            wb_data      = $urandom;
            #1;
            total++;
            if ({in_ready, readReg1, readReg2} !== {model_ready(), rs, rt}) begin
                bad++; $display("FAIL rnd_comb n=%0d got rdy=%b r1=%0d r2=%0d exp rdy=%b r1=%0d r2=%0d",
                                n, in_ready, readReg1, readReg2, model_ready(), rs, rt);
            end
            tick();
            total++;
            if ({ex_valid, ex_regwrite, ex_memread} !== {m_valid, m_rw, m_mr}) begin
                bad++; $display("FAIL rnd_ctrl n=%0d got v/rw/mr=%b%b%b exp %b%b%b",
                                n, ex_valid, ex_regwrite, ex_memread, m_valid, m_rw, m_mr);
            end
            if (m_valid) begin
                total++;
                if ({ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_opcode, ex_funct, ex_dest} !==
                    {m_pc, m_rs, m_rt, m_imm, m_op, m_fn, m_dest}) begin
                    bad++; $display("FAIL rnd_data n=%0d got pc=%h rs=%h rt=%h imm=%h op=%h fn=%h d=%0d exp pc=%h rs=%h rt=%h imm=%h op=%h fn=%h d=%0d",
                                    n, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_opcode, ex_funct, ex_dest,
                                    m_pc, m_rs, m_rt, m_imm, m_op, m_fn, m_dest);
                end
            end
        end
    endtask

    initial begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_pc = 0; m_rs = 0; m_rt = 0;
        m_imm = 0; m_op = 0; m_fn = 0; m_dest = 0; m_pend = 0;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_wb_bypass();
        test_zero_dest();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
